pulse_period_meter: RTL and testbench

Measures the spacing, in `clk` cycles, between successive rising edges of a single-bit pulse stream. It is the receive-side counterpart of the `clk_pulse` divider: a pulse train emitted every N cycles reads back as `period = N`. It sits next to any pulse or strobe generator as an in-system rate checker. It also gives software or control logic a lock indicator and a loss-of-pulse timeout.

---
 rtl/pulse_meter_pkg.sv | 7 +
 rtl/sync_edge_detect.sv | 23 ++
 rtl/pulse_period_meter.sv | 80 ++++++++
 tb/tb_pulse_period_meter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared state type and default sizing for pulse_period_meter.
package pulse_meter_pkg;
    typedef enum logic {S_IDLE, S_RUN} pm_state_t;
    localparam int PM_WIDTH = 32;
    localparam int PM_SYNC_STAGES = 2;
    localparam int PM_LOCK_COUNT = 4;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes pulse_in and flags each rising edge for one cycle.
module sync_edge_detect
    import pulse_meter_pkg::*;
#(
    parameter int SYNC_STAGES = PM_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic pulse_in,
    output logic pulse_edge
);
    logic [SYNC_STAGES-1:0] sync;
    logic s_d;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync <= '0;
            s_d <= 1'b0;
        end else begin
            sync <= (sync << 1) | SYNC_STAGES'(pulse_in);
            s_d <= sync[SYNC_STAGES-1];
        end
    assign pulse_edge = sync[SYNC_STAGES-1] & ~s_d;
endmodule

// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures clk cycles between rising edges of pulse_in, with lock and timeout.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int WIDTH = PM_WIDTH,
    parameter int SYNC_STAGES = PM_SYNC_STAGES,
    parameter int LOCK_COUNT = PM_LOCK_COUNT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             clear,
    input  logic [WIDTH-1:0] timeout_limit,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);
    localparam int MW = $clog2(LOCK_COUNT);
    localparam logic [MW-1:0] M_MAX = MW'(LOCK_COUNT - 1);
    pm_state_t state, state_n;
    logic [WIDTH-1:0] cnt;
    logic [MW-1:0] match_cnt, match_n;
    logic have_ref, pulse_edge, report, expire, same;
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .pulse_in(pulse_in),
        .pulse_edge(pulse_edge)
    );
    always_comb begin
        report = state == S_RUN && pulse_edge;
        expire = state == S_RUN && !pulse_edge && timeout_limit != '0 && cnt >= timeout_limit;
        state_n = pulse_edge ? S_RUN : expire ? S_IDLE : state;
        same = have_ref && cnt == period;
        match_n = match_cnt == M_MAX ? M_MAX : match_cnt + 1'b1;
    end
    // have_ref keeps the first report after arming or timeout from matching a stale period
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            cnt <= '0;
            period <= '0;
            period_valid <= 1'b0;
            locked <= 1'b0;
            timeout <= 1'b0;
            match_cnt <= '0;
            have_ref <= 1'b0;
        end else if (clear) begin
            state <= S_IDLE;
            cnt <= '0;
            period <= '0;
            period_valid <= 1'b0;
            locked <= 1'b0;
            timeout <= 1'b0;
            match_cnt <= '0;
            have_ref <= 1'b0;
        end else begin
            state <= state_n;
            period_valid <= report;
            if (pulse_edge) begin
                cnt <= WIDTH'(1);
                timeout <= 1'b0;
            end else if (expire) begin
                cnt <= '0;
                timeout <= 1'b1;
                locked <= 1'b0;
                match_cnt <= '0;
                have_ref <= 1'b0;
            end else if (state == S_RUN && !(&cnt)) begin
                cnt <= cnt + 1'b1;
            end
            if (report) begin
                period <= cnt;
                have_ref <= 1'b1;
                match_cnt <= same ? match_n : '0;
                locked <= same && match_n == M_MAX;
            end
        end
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: table-driven and scoreboarded checks of pulse_period_meter.
module tb_pulse_period_meter;
    logic clk = 1'b0, reset = 1'b1, pulse_in = 1'b0, clear = 1'b0;
    logic [31:0] timeout_limit = '0, period;
    logic period_valid, locked, timeout;
    logic [3:0] p4;
    logic v4, l4, t4;
    typedef struct packed { logic [31:0] p; logic lk; } exp_t;
    typedef struct { int gap; bit rep; logic [31:0] p; bit lk; } vec_t;
    exp_t q[$];
    exp_t mon_e;
    vec_t tbl[12];
    int n_cmp = 0, n_bad = 0, n;
    always #5 clk = ~clk;
    pulse_period_meter dut (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .clear(clear),
        .timeout_limit(timeout_limit), .period(period), .period_valid(period_valid),
        .locked(locked), .timeout(timeout)
    );
    pulse_period_meter #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .clear(clear),
        .timeout_limit(4'd0), .period(p4), .period_valid(v4),
        .locked(l4), .timeout(t4)
    );
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask
    always @(negedge clk)
        if (period_valid) begin
            if (q.size() == 0) chk("unexpected_strobe", 32'd1, 32'd0);
            else begin
                mon_e = q.pop_front();
                chk("period", period, mon_e.p);
                chk("locked", 32'(locked), 32'(mon_e.lk));
            end
        end
    // rises of pulse_in are spaced gap cycles apart when called back to back
    task automatic send(int gap, bit rep, logic [31:0] p, bit lk);
        repeat (gap - 1) @(posedge clk);
        #1 pulse_in = 1'b1;
        if (rep) q.push_back({p, lk});
        @(posedge clk);
        #1 pulse_in = 1'b0;
    endtask
    task automatic drain(string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk(name, 32'(q.size()), 32'd0);
    endtask
    task automatic do_clear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl = '{'{1, 0, 0, 0}, '{5, 1, 5, 0}, '{5, 1, 5, 0}, '{5, 1, 5, 0},
                '{5, 1, 5, 1}, '{5, 1, 5, 1}, '{3, 1, 3, 0}, '{3, 1, 3, 0},
                '{3, 1, 3, 0}, '{3, 1, 3, 1}, '{3, 1, 3, 1}, '{7, 1, 7, 0}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", period, 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        foreach (tbl[i]) send(tbl[i].gap, tbl[i].rep, tbl[i].p, tbl[i].lk);
        drain("drain_steady");
        do_clear();
        timeout_limit = 20;
        send(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(10, 1, 10, i == 3);
        for (int i = 0; i < 10 && !period_valid; i++) @(negedge clk);
        chk("to_last_strobe", 32'(period_valid), 32'd1);
        n = 0;
        while (n < 40 && !timeout) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_delay", n, 32'd20);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_period_hold", period, 32'd10);
        @(posedge clk);
        #1 timeout_limit = 10;
        send(1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("to_cleared", 32'(timeout), 32'd0);
        send(7, 1, 10, 0);
        for (int i = 0; i < 3; i++) send(10, 1, 10, i == 2);
        drain("drain_timeout");
        chk("edge_beats_timeout", 32'(timeout), 32'd0);
        chk("relock", 32'(locked), 32'd1);
        do_clear();
        timeout_limit = 0;
        send(1, 0, 0, 0);
        send(30, 1, 30, 0);
        for (int i = 0; i < 10 && !v4; i++) @(negedge clk);
        chk("sat_valid", 32'(v4), 32'd1);
        chk("sat_period", 32'(p4), 32'd15);
        chk("sat_locked", 32'(l4), 32'd0);
        chk("sat_timeout", 32'(t4), 32'd0);
        @(posedge clk);
        #1;
        drain("drain_sat");
        do_clear();
        pulse_in = 1'b1;
        repeat (50) @(posedge clk);
        #1 pulse_in = 1'b0;
        send(11, 1, 60, 0);
        drain("drain_held");
        do_clear();
        send(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) send(4, 1, 4, i == 3);
        drain("drain_prereset");
        chk("prereset_locked", 32'(locked), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_period", period, 32'd0);
        chk("mid_rst_valid", 32'(period_valid), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        send(1, 0, 0, 0);
        send(6, 1, 6, 0);
        drain("drain_postreset");
        pulse_in = 1'b1;
        @(posedge clk);
        #1 pulse_in = 1'b0;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        chk("clr_period", period, 32'd0);
        chk("clr_valid", 32'(period_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        send(1, 0, 0, 0);
        send(5, 1, 5, 0);
        drain("drain_clear");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
